// File: rtl/fifo36_rd_stream.sv
// fifo36_rd_stream: read-side drain stage for a 36Kb FIFO primitive in its
// synchronous configuration. Issues read enables on a credit basis, absorbs
// the 1- or 2-cycle read latency in a 4-entry skid buffer and presents the
// words as a valid/ready stream with parity and ECC flags alongside.
// Optional build macro FIFO36_RD_STREAM_ERRCNT_EN adds saturating per-flag
// error counters (SBITERR_CNT/DBITERR_CNT) with a clear input (ERRCNT_CLR).
module fifo36_rd_stream #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned PAR_WIDTH    = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RDEN,
  input  logic [DATA_WIDTH-1:0] FIFO_DO,
  input  logic [PAR_WIDTH-1:0]  FIFO_DOP,
  input  logic                  FIFO_SBITERR,
  input  logic                  FIFO_DBITERR,
`ifdef FIFO36_RD_STREAM_ERRCNT_EN
  input  logic                  ERRCNT_CLR,
  output logic [15:0]           SBITERR_CNT,
  output logic [15:0]           DBITERR_CNT,
`endif
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic [PAR_WIDTH-1:0]  M_PAR,
  output logic                  M_SBITERR,
  output logic                  M_DBITERR
);

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ENTRY_W = DATA_WIDTH + PAR_WIDTH + 2;

  // Reject configurations the primitive cannot produce.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("fifo36_rd_stream: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH < 4 || DATA_WIDTH > 64) begin : g_bad_data_width
    $error("fifo36_rd_stream: DATA_WIDTH must be in 4..64");
  end
  if (PAR_WIDTH == 0) begin : g_bad_par_width
    $error("fifo36_rd_stream: PAR_WIDTH must be non-zero");
  end

  logic [READ_LATENCY-1:0] inflight;
  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        occ;
  logic [CNT_W-1:0]        occ_nxt;
  logic [CNT_W-1:0]        inflight_cnt;
  logic [CNT_W-1:0]        credit_cnt;
  logic [ENTRY_W-1:0]      head_entry;
  logic                    capture;
  logic                    pop;

  // A word lands on DO when its read enable reaches the end of the pipe.
  assign capture = inflight[READ_LATENCY-1];
  assign pop     = M_VALID && M_READY;

  // Count reads still travelling through the primitive's output pipeline.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(inflight[i]);
    end
  end

  // Every slot is spoken for once buffered plus in-flight words reach DEPTH,
  // so a capture can never find the buffer full. Only registered state and
  // EMPTY feed the enable; M_READY is deliberately kept out of this path.
  assign credit_cnt = occ + inflight_cnt;
  assign FIFO_RDEN  = !RST && !FIFO_EMPTY && (credit_cnt < CNT_W'(DEPTH));

  // Occupancy update; simultaneous capture and pop cancel out.
  always_comb begin
    occ_nxt = occ;
    if (capture && !pop) begin
      occ_nxt = occ + CNT_W'(1);
    end else if (!capture && pop) begin
      occ_nxt = occ - CNT_W'(1);
    end
  end

  // In-flight pipe, circular buffer storage and pointers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight <= '0;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Drop the oldest bit, shift in this cycle's read enable.
      inflight <= READ_LATENCY'({inflight, FIFO_RDEN});
      if (capture) begin
        mem[tail] <= {FIFO_DO, FIFO_DOP, FIFO_SBITERR, FIFO_DBITERR};
        tail      <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      occ <= occ_nxt;
    end
  end

  // Stream outputs come straight from the head slot, so they cannot change
  // while a word waits for M_READY.
  assign head_entry = mem[head];
  assign M_VALID    = (occ != '0);
  assign M_DATA     = head_entry[ENTRY_W-1 -: DATA_WIDTH];
  assign M_PAR      = head_entry[PAR_WIDTH+1 -: PAR_WIDTH];
  assign M_SBITERR  = head_entry[1];
  assign M_DBITERR  = head_entry[0];

`ifdef FIFO36_RD_STREAM_ERRCNT_EN
  // Saturating counts of flagged words handed to the consumer; clear wins.
  always_ff @(posedge CLK) begin
    if (RST || ERRCNT_CLR) begin
      SBITERR_CNT <= '0;
      DBITERR_CNT <= '0;
    end else begin
      if (pop && M_SBITERR && (SBITERR_CNT != 16'hFFFF)) begin
        SBITERR_CNT <= SBITERR_CNT + 16'd1;
      end
      if (pop && M_DBITERR && (DBITERR_CNT != 16'hFFFF)) begin
        DBITERR_CNT <= DBITERR_CNT + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo36_rd_stream.sv
// Bench for fifo36_rd_stream: two instances (READ_LATENCY 1 and 2) share one
// stimulus stream; each has its own FIFO model and scoreboard monitor.
// Build with FIFO36_RD_STREAM_ERRCNT_EN defined to also check the counters.
module tb_fifo36_rd_stream;

  localparam int unsigned DW   = 64;
  localparam int unsigned PW   = 8;
  localparam int unsigned NL   = 2;
  localparam int unsigned MEMD = 4096;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    logic          s;
    logic          e;
  } word_t;

  // Value on DO when no read is completing; the DUT must never capture it.
  localparam word_t GARB = {64'hBAD0_BAD0_BAD0_BAD0, 8'hA5, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst;
  logic m_ready;
`ifdef FIFO36_RD_STREAM_ERRCNT_EN
  logic errcnt_clr;
`endif

  int errs   = 0;
  int checks = 0;

  // Words written into the FIFO, shared by both lanes; each lane reads its own copy.
  word_t fmem [MEMD];
  int    wr_ptr = 0;

  logic [NL-1:0] vld;
  logic [NL-1:0] rdn;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int unsigned LAT = g + 1;

    logic          fifo_empty, fifo_rden, fifo_sb, fifo_db;
    logic [DW-1:0] fifo_do, m_data;
    logic [PW-1:0] fifo_dop, m_par;
    logic          m_valid, m_sb, m_db;
`ifdef FIFO36_RD_STREAM_ERRCNT_EN
    logic [15:0]   sb_cnt, db_cnt;
`endif

    int             rd_ptr  = 0;
    int             n_reads = 0;
    int             n_pops  = 0;
    logic [LAT-1:0] pvl     = '0;
    int             pidx [LAT];
    word_t          cur, mw, hold_w, e;
    logic           stall_prev = 1'b0;
    word_t          exp_q [$];

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign cur        = pvl[LAT-1] ? fmem[pidx[LAT-1]] : GARB;
    assign {fifo_do, fifo_dop, fifo_sb, fifo_db} = cur;
    assign mw         = {m_data, m_par, m_sb, m_db};
    assign vld[g]     = m_valid;
    assign rdn[g]     = fifo_rden;

    fifo36_rd_stream #(
      .DATA_WIDTH  (DW),
      .PAR_WIDTH   (PW),
      .READ_LATENCY(LAT)
    ) dut (
      .CLK         (clk),
      .RST         (rst),
      .FIFO_EMPTY  (fifo_empty),
      .FIFO_RDEN   (fifo_rden),
      .FIFO_DO     (fifo_do),
      .FIFO_DOP    (fifo_dop),
      .FIFO_SBITERR(fifo_sb),
      .FIFO_DBITERR(fifo_db),
`ifdef FIFO36_RD_STREAM_ERRCNT_EN
      .ERRCNT_CLR  (errcnt_clr),
      .SBITERR_CNT (sb_cnt),
      .DBITERR_CNT (db_cnt),
`endif
      .M_VALID     (m_valid),
      .M_READY     (m_ready),
      .M_DATA      (m_data),
      .M_PAR       (m_par),
      .M_SBITERR   (m_sb),
      .M_DBITERR   (m_db)
    );

    // FIFO model: a read sampled at an edge shows its word LAT cycles later.
    always @(posedge clk) begin
      if (rst) begin
        rd_ptr  <= wr_ptr;
        n_reads <= 0;
        pvl     <= '0;
      end else begin
        if (fifo_rden) begin
          chk($sformatf("L%0d rden_not_empty", LAT), fifo_empty, 1'b0);
          rd_ptr  <= rd_ptr + 1;
          n_reads <= n_reads + 1;
        end
        pvl     <= LAT'({pvl, fifo_rden});
        pidx[0] <= rd_ptr;
        for (int i = 1; i < int'(LAT); i++) pidx[i] <= pidx[i-1];
      end
    end

    // Monitor: order/content scoreboard, hold-while-stalled, credit bound.
    always @(negedge clk) begin
      if (rst) begin
        stall_prev = 1'b0;
        n_pops     = 0;
      end else begin
        if (fifo_rden)
          chk($sformatf("L%0d credit_le4", LAT), ((n_reads + 1 - n_pops) <= 4), 1'b1);
        if (stall_prev) begin
          chk($sformatf("L%0d hold_valid", LAT), m_valid, 1'b1);
          chk($sformatf("L%0d hold_word", LAT), mw, hold_w);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("L%0d unexpected_word", LAT), mw, GARB);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("L%0d word", LAT), mw, e);
          end
          n_pops++;
        end
        stall_prev = m_valid && !m_ready;
        hold_w     = mw;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input word_t w);
    fmem[wr_ptr] = w;
    wr_ptr++;
    lane[0].exp_q.push_back(w);
    lane[1].exp_q.push_back(w);
  endtask

  task automatic put_seq(input int first, input int n, input int dbit_idx, input int sbit_idx);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.d = DW'(first + i);
      w.p = PW'(first + i);
      w.s = (i == sbit_idx);
      w.e = (i == dbit_idx);
      put(w);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((lane[0].exp_q.size() + lane[1].exp_q.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    chk({name, " drained"}, lane[0].exp_q.size() + lane[1].exp_q.size(), 0);
    repeat (4) step();
  endtask

  initial begin
    int    pulses [NL];
    word_t w;
    int    sent;

    rst     = 1'b1;
    m_ready = 1'b0;
`ifdef FIFO36_RD_STREAM_ERRCNT_EN
    errcnt_clr = 1'b0;
`endif
    repeat (3) step();

    // Reset state.
    chk("rst vld", vld, 2'b00);
    chk("rst rden", rdn, 2'b00);
    chk("rst word L1", lane[0].mw, 0);
    chk("rst word L2", lane[1].mw, 0);
    rst = 1'b0;
    repeat (2) step();

    // Latency and back-to-back throughput.
    m_ready = 1'b1;
    chk("lat rden_before", rdn, 2'b00);
    put_seq(0, 10, -1, -1);
    #1;
    chk("lat rden_first", rdn, 2'b11);
    for (int c = 1; c <= 14; c++) begin
      step();
      for (int g = 0; g < int'(NL); g++)
        chk($sformatf("lat L%0d c%0d vld", g + 1, c), vld[g],
            (c >= g + 2) && (c <= g + 11));
    end
    drain("lat", 50);

    // Stall: credit limit must stop reads at four.
    m_ready = 1'b0;
    pulses  = '{0, 0};
    put_seq(0, 10, -1, -1);
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      for (int g = 0; g < int'(NL); g++) pulses[g] += int'(rdn[g]);
    end
    chk("stall pulses L1", pulses[0], 4);
    chk("stall pulses L2", pulses[1], 4);
    chk("stall head L1", lane[0].m_data, 0);
    chk("stall head L2", lane[1].m_data, 0);
    chk("stall vld", vld, 2'b11);
    m_ready = 1'b1;
    drain("stall", 50);

    // ECC flags travel with their words.
`ifdef FIFO36_RD_STREAM_ERRCNT_EN
    errcnt_clr = 1'b1;
    step();
    errcnt_clr = 1'b0;
`endif
    put_seq(0, 10, 5, 7);
    drain("ecc", 50);
`ifdef FIFO36_RD_STREAM_ERRCNT_EN
    chk("errcnt sb L1", lane[0].sb_cnt, 1);
    chk("errcnt db L1", lane[0].db_cnt, 1);
    chk("errcnt sb L2", lane[1].sb_cnt, 1);
    chk("errcnt db L2", lane[1].db_cnt, 1);
    errcnt_clr = 1'b1;
    step();
    errcnt_clr = 1'b0;
    chk("errcnt clr L1", {lane[0].sb_cnt, lane[0].db_cnt}, 0);
    chk("errcnt clr L2", {lane[1].sb_cnt, lane[1].db_cnt}, 0);
`endif

    // Random writes and random back-pressure.
    sent = 0;
    while (sent < 1000) begin
      m_ready = 1'($urandom % 2);
      if (($urandom % 2) == 0) begin
        w.d = {$urandom, $urandom};
        w.p = PW'($urandom);
        w.s = (($urandom % 8) == 0);
        w.e = (($urandom % 8) == 0);
        put(w);
        sent++;
      end
      step();
    end
    m_ready = 1'b1;
    drain("random", 200);

    // Reset mid-operation discards buffered and in-flight words.
    m_ready = 1'b0;
    put_seq(0, 10, -1, -1);
    repeat (4) step();
    rst = 1'b1;
    lane[0].exp_q.delete();
    lane[1].exp_q.delete();
    #1;
    chk("midrst rden_during", rdn, 2'b00);
    step();
    rst = 1'b0;
    chk("midrst vld", vld, 2'b00);
    chk("midrst rden", rdn, 2'b00);
    step();
    put_seq(10, 2, -1, -1);
    m_ready = 1'b1;
    drain("midrst", 50);
    repeat (6) step();
    chk("midrst idle vld", vld, 2'b00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fifo36_rd_stream.md
Name: fifo36_rd_stream

Overview:
- Read-side drain stage directly downstream of the 36Kb FIFO primitive, in its synchronous (EN_SYN) configuration.
- Issues FIFO read enables and absorbs the 1- or 2-cycle read latency (set by DO_REG) in a 4-entry skid buffer.
- Presents the read words as a valid/ready stream with parity and ECC error flags carried alongside.
- Never reads an empty FIFO, so it never causes RDERR.

Parameters:
- DATA_WIDTH, 64, width of FIFO DO and stream data (legal: 4..64).
- PAR_WIDTH, 8, width of FIFO DOP and stream parity (0 is not legal; tie off unused bits).
- READ_LATENCY, 2, cycles from RDEN sample to DO valid; 1 matches DO_REG=0, 2 matches DO_REG=1. Any other value is a compile-time error.

Ports:
- CLK  in  1  single clock; also drives the FIFO RDCLK/WRCLK.
- RST  in  1  synchronous, active-high reset.
- FIFO_EMPTY  in  1  FIFO EMPTY flag.
- FIFO_RDEN  out  1  FIFO RDEN.
- FIFO_DO  in  DATA_WIDTH  FIFO DO.
- FIFO_DOP  in  PAR_WIDTH  FIFO DOP.
- FIFO_SBITERR  in  1  FIFO single-bit ECC error, aligned with DO.
- FIFO_DBITERR  in  1  FIFO double-bit ECC error, aligned with DO.
- M_VALID  out  1  stream word valid.
- M_READY  in  1  downstream accepts.
- M_DATA  out  DATA_WIDTH  stream data.
- M_PAR  out  PAR_WIDTH  stream parity.
- M_SBITERR  out  1  word had a corrected single-bit error.
- M_DBITERR  out  1  word is corrupt (double-bit error).

Behaviour:
- Reset, held while RST=1 and applied on the clock edge:
  - FIFO_RDEN=0, M_VALID=0, M_DATA/M_PAR/M_SBITERR/M_DBITERR=0.
  - Buffer occupancy=0, in-flight pipe cleared.
- Reset mid-operation: words already read but still in flight or buffered are discarded. The system resets the FIFO in the same cycle.
- In-flight tracking:
  - READ_LATENCY-deep shift register of valid bits, fed by FIFO_RDEN.
  - Its output strobes capture of {DO, DOP, SBITERR, DBITERR} into the buffer tail.
- Credit rule:
  - count = occupancy + in-flight entries (0..4).
  - FIFO_RDEN = !RST && !FIFO_EMPTY && (count < 4).
  - FIFO_RDEN depends only on registered state and FIFO_EMPTY, never combinationally on M_READY.
  - The buffer therefore never overflows: capture into a full buffer is impossible by construction. The bench asserts this.
- Buffer:
  - 4-entry circular buffer; 2-bit head and tail pointers wrap modulo 4.
  - Occupancy is a 3-bit counter.
  - Capture and pop in the same cycle leave occupancy unchanged.
- Output:
  - M_VALID = (occupancy != 0).
  - M_DATA, M_PAR and the flags come from the head entry.
  - Pop when M_VALID && M_READY.
  - While M_VALID=1 and M_READY=0, all M_* outputs stay stable.
- Latency: with the buffer empty, a word read with FIFO_RDEN high in cycle t gives M_VALID=1 in cycle t+READ_LATENCY+1.
- Throughput:
  - With M_READY held at 1 and FIFO non-empty, one word per cycle sustained; steady-state count ≤ READ_LATENCY+1.
  - Word order is preserved exactly.
- Boundaries:
  - FIFO_EMPTY asserting while reads are in flight does not affect them.
  - FIFO_EMPTY rising in the same cycle as a read attempt suppresses FIFO_RDEN that cycle.
  - DBITERR words are forwarded, not dropped; the consumer decides.

Optional Feature:
- Macro: FIFO36_RD_STREAM_ERRCNT_EN.
- When defined, adds:
  - Input ERRCNT_CLR (1 bit).
  - Outputs SBITERR_CNT[15:0] and DBITERR_CNT[15:0].
- Counter rules:
  - Each counter increments by one per popped word carrying the matching flag.
  - Counters saturate at 16'hFFFF.
  - Counters clear to 0 on RST or ERRCNT_CLR; clear wins over a same-cycle increment.
- When undefined: those ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- READ_LATENCY=2, FIFO preloaded with 0x0..0x9, M_READY=1 -> FIFO_RDEN first high in cycle t; M_VALID first high at t+3; M_DATA 0x0..0x9 on 10 consecutive cycles with no gaps.
- Same load, M_READY=0 for 20 cycles then 1 -> exactly 4 FIFO_RDEN pulses before the stall; no overflow; M_DATA=0x0 stable; then all 10 words in order.
- Random M_READY (50%), 1000 random words, READ_LATENCY=1 and 2 -> output sequence equals input sequence; FIFO_RDEN never high while FIFO_EMPTY=1.
- Word 5 carries DBITERR=1 and word 7 carries SBITERR=1 -> M_DBITERR=1 only with word 5 and M_SBITERR=1 only with word 7. With FIFO36_RD_STREAM_ERRCNT_EN: counts read DBITERR_CNT=1, SBITERR_CNT=1; ERRCNT_CLR pulse returns both to 0.
- RST asserted for 1 cycle with 2 words buffered and 2 in flight -> next cycle M_VALID=0 and FIFO_RDEN=0; after RST drops and the FIFO is refilled with 0xA, 0xB -> output is 0xA, 0xB only.
